layer_sequencer: RTL and testbench

- Sequences one forward pass of the neural network over a single shared MAC/activation datapath.
- Consumes the per-layer configuration words and layer count produced by the instruction unit.
- Walks layer -> neuron -> input, and drives operand indices, weight addresses, accumulator clear, bias, activation and write-back strobes.
- Sits between the instruction unit and the MAC/activation/neuron-memory blocks.

---
 rtl/layer_sequencer.sv | 167 ++++++++++++++++
 tb/tb_layer_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Forward-pass sequencer: walks layer -> neuron -> input over one shared MAC/activation datapath.
// Optional cycle counter output oCiclos is built when LAYER_SEQUENCER_PERF_EN is defined.
module layer_sequencer #(
    parameter int ADDR_W  = 10,
    parameter int MAX_CAM = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iStart,
    input  logic                   iCfgOK,
    input  logic [2:0]             iQtdCamadas,
    input  logic [13*MAX_CAM-1:0]  iCfg,
    input  logic                   iMacRdy,
    output logic [1:0]             oLayer,
    output logic [4:0]             oNeuron,
    output logic [4:0]             oAddrX,
    output logic [ADDR_W-1:0]      oAddrW,
    output logic                   oMacClr,
    output logic                   oMacEn,
    output logic                   oBiasEn,
    output logic                   oActEn,
    output logic [1:0]             oFA,
    output logic                   oWrEn,
    output logic                   oBusy,
    output logic                   oDone
`ifdef LAYER_SEQUENCER_PERF_EN
    ,
    output logic [15:0]            oCiclos
`endif
);

    typedef struct packed {
        logic [4:0] neurons;
        logic       bias;
        logic [1:0] fa;
        logic [4:0] inputs;
    } cfg_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLR, S_MAC, S_BIAS, S_ACT, S_WB, S_DONE
    } state_t;

    state_t            state, nstate;
    cfg_t              cfg_q, cfg_sel;
    logic [1:0]        layer;
    logic [4:0]        neuron, inp;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        cnt, cnt_clamp;
    logic              accept, layer_more, nrn_more, inp_last;

    assign accept     = iStart & iCfgOK;
    assign cnt_clamp  = (iQtdCamadas > 3'(MAX_CAM)) ? 3'(MAX_CAM) : iQtdCamadas;
    assign cfg_sel    = cfg_t'(iCfg[13*int'(layer) +: 13]);
    assign layer_more = ({1'b0, layer} + 3'd1) < cnt;
    assign nrn_more   = ({1'b0, neuron} + 6'd1) < {1'b0, cfg_q.neurons};
    assign inp_last   = (inp + 5'd1) == cfg_q.inputs;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nstate;
    end

    always_comb begin
        nstate  = state;
        oMacClr = 1'b0;
        oMacEn  = 1'b0;
        oBiasEn = 1'b0;
        oActEn  = 1'b0;
        oWrEn   = 1'b0;
        oDone   = 1'b0;
        oBusy   = 1'b1;
        case (state)
            S_IDLE: begin
                oBusy = 1'b0;
                if (accept) nstate = S_LOAD;
            end
            S_LOAD: begin
                // the neuron count is judged on the word being latched this cycle
                if (cnt == 3'd0)                  nstate = S_DONE;
                else if (cfg_sel.neurons == 5'd0) nstate = layer_more ? S_LOAD : S_DONE;
                else                              nstate = S_CLR;
            end
            S_CLR: begin
                oMacClr = 1'b1;
                if (cfg_q.inputs != 5'd0) nstate = S_MAC;
                else if (cfg_q.bias)      nstate = S_BIAS;
                else                      nstate = S_ACT;
            end
            S_MAC: begin
                oMacEn = 1'b1;
                if (iMacRdy && inp_last) nstate = cfg_q.bias ? S_BIAS : S_ACT;
            end
            S_BIAS: begin
                oBiasEn = 1'b1;
                if (iMacRdy) nstate = S_ACT;
            end
            S_ACT: begin
                oActEn = 1'b1;
                nstate = S_WB;
            end
            S_WB: begin
                oWrEn = 1'b1;
                if (nrn_more)        nstate = S_CLR;
                else if (layer_more) nstate = S_LOAD;
                else                 nstate = S_DONE;
            end
            S_DONE: begin
                oDone  = 1'b1;
                nstate = S_IDLE;
            end
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            cfg_q  <= '0;
            layer  <= '0;
            neuron <= '0;
            inp    <= '0;
            addr   <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    layer <= '0;
                    addr  <= '0;
                    cnt   <= cnt_clamp;
                end
                S_LOAD: begin
                    cfg_q  <= cfg_sel;
                    neuron <= '0;
                    if (cnt != 3'd0 && cfg_sel.neurons == 5'd0 && layer_more)
                        layer <= layer + 2'd1;
                end
                S_CLR: inp <= '0;
                S_MAC: if (iMacRdy) begin
                    addr <= addr + 1'b1;
                    inp  <= inp + 5'd1;
                end
                S_BIAS: if (iMacRdy) addr <= addr + 1'b1;
                S_WB: begin
                    if (nrn_more)        neuron <= neuron + 5'd1;
                    else if (layer_more) layer  <= layer + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign oLayer  = layer;
    assign oNeuron = neuron;
    assign oAddrX  = inp;
    assign oAddrW  = addr;
    assign oFA     = cfg_q.fa;

`ifdef LAYER_SEQUENCER_PERF_EN
    always_ff @(negedge clk or negedge rst) begin
        if (!rst)                    oCiclos <= '0;
        else if (state == S_IDLE) begin
            if (accept)              oCiclos <= '0;
        end
        else if (oCiclos != 16'hFFFF) oCiclos <= oCiclos + 16'd1;
    end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: per-pass expected trace built from the layer configs, checked every cycle.
module tb_layer_sequencer;
    localparam int ADDR_W  = 10;
    localparam int MAX_CAM = 4;

    logic                  clk = 1'b1;
    logic                  rst = 1'b1;
    logic                  iStart = 1'b0, iCfgOK = 1'b0, iMacRdy = 1'b1;
    logic [2:0]            iQtdCamadas = '0;
    logic [13*MAX_CAM-1:0] iCfg = '0;
    logic [1:0]            oLayer, oFA;
    logic [4:0]            oNeuron, oAddrX;
    logic [ADDR_W-1:0]     oAddrW;
    logic                  oMacClr, oMacEn, oBiasEn, oActEn, oWrEn, oBusy, oDone;
`ifdef LAYER_SEQUENCER_PERF_EN
    logic [15:0]           oCiclos;
`endif

    layer_sequencer #(.ADDR_W(ADDR_W), .MAX_CAM(MAX_CAM)) dut (
        .clk(clk), .rst(rst), .iStart(iStart), .iCfgOK(iCfgOK), .iQtdCamadas(iQtdCamadas),
        .iCfg(iCfg), .iMacRdy(iMacRdy), .oLayer(oLayer), .oNeuron(oNeuron), .oAddrX(oAddrX),
        .oAddrW(oAddrW), .oMacClr(oMacClr), .oMacEn(oMacEn), .oBiasEn(oBiasEn), .oActEn(oActEn),
        .oFA(oFA), .oWrEn(oWrEn), .oBusy(oBusy), .oDone(oDone)
`ifdef LAYER_SEQUENCER_PERF_EN
        , .oCiclos(oCiclos)
`endif
    );

    always #5 clk = ~clk;

    typedef enum int {K_LOAD, K_CLR, K_MAC, K_BIAS, K_ACT, K_WB, K_DONE} kind_e;
    typedef struct {
        kind_e k;
        int    layer, neuron, x, w, fa;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0;
    int   busy_cnt, wr_cnt, done_cnt, pc;
    int   addr_log[$], bias_log[$], wrl_log[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] lc(input int neu, input int b, input int fa, input int ni);
        return {5'(neu), 1'(b), 2'(fa), 5'(ni)};
    endfunction

    function automatic void push(input kind_e k, input int l, input int n, input int x,
                                 input int w, input int fa);
        exp_t e;
        e.k = k; e.layer = l; e.neuron = n; e.x = x; e.w = w; e.fa = fa;
        q.push_back(e);
    endfunction

    // expected cycle trace of one unstalled pass; stalls are absorbed by the compare process
    function automatic void build(input logic [13*MAX_CAM-1:0] cfg, input int qtd);
        int nl = (qtd > MAX_CAM) ? MAX_CAM : qtd;
        int a = 0;
        if (nl == 0) push(K_LOAD, 0, 0, 0, 0, 0);
        for (int l = 0; l < nl; l++) begin
            int neu = int'(cfg[13*l+8 +: 5]);
            int b   = int'(cfg[13*l+7]);
            int fa  = int'(cfg[13*l+5 +: 2]);
            int ni  = int'(cfg[13*l +: 5]);
            push(K_LOAD, l, 0, 0, 0, 0);
            for (int n = 0; n < neu; n++) begin
                push(K_CLR, l, n, 0, 0, fa);
                for (int i = 0; i < ni; i++) begin
                    push(K_MAC, l, n, i, a % 1024, fa);
                    a++;
                end
                if (b != 0) begin
                    push(K_BIAS, l, n, 0, a % 1024, fa);
                    a++;
                end
                push(K_ACT, l, n, 0, 0, fa);
                push(K_WB, l, n, 0, 0, fa);
            end
        end
        push(K_DONE, 0, 0, 0, 0, 0);
        pc = 0;
    endfunction

    initial begin
        forever begin
            exp_t e;
            @(posedge clk); #1;
            if (!rst) begin
                chk("rst_outs", {oBusy, oDone, oMacClr, oMacEn, oBiasEn, oActEn, oWrEn,
                                 oLayer, oNeuron, oAddrX, oAddrW, oFA}, 0);
            end else if (q.size() == 0) begin
                chk("idle_strobes", {oBusy, oDone, oMacClr, oMacEn, oBiasEn, oActEn, oWrEn}, 0);
            end else begin
                e = q[0];
                chk("strobes", {oBusy, oDone, oMacClr, oMacEn, oBiasEn, oActEn, oWrEn},
                    {1'b1, e.k == K_DONE, e.k == K_CLR, e.k == K_MAC, e.k == K_BIAS,
                     e.k == K_ACT, e.k == K_WB});
                if (e.k != K_DONE) chk("layer", oLayer, e.layer);
                if (e.k != K_DONE && e.k != K_LOAD) begin
                    chk("neuron", oNeuron, e.neuron);
                    chk("fa", oFA, e.fa);
                end
                if (e.k == K_MAC) chk("addrx", oAddrX, e.x);
                if (e.k == K_MAC || e.k == K_BIAS) chk("addrw", oAddrW, e.w);
`ifdef LAYER_SEQUENCER_PERF_EN
                chk("ciclos", oCiclos, pc);
`endif
                pc++;
                if (oBusy) busy_cnt++;
                if (oDone) done_cnt++;
                if (oWrEn) begin
                    wr_cnt++;
                    wrl_log.push_back(int'(oLayer));
                end
                if ((oMacEn || oBiasEn) && iMacRdy) begin
                    addr_log.push_back(int'(oAddrW));
                    if (oBiasEn) bias_log.push_back(addr_log.size() - 1);
                end
                if (!((e.k == K_MAC || e.k == K_BIAS) && !iMacRdy)) void'(q.pop_front());
            end
        end
    end

    task automatic start_pass(input logic [13*MAX_CAM-1:0] cfg, input logic [2:0] qtd);
        @(negedge clk); #1;
        iCfg = cfg; iQtdCamadas = qtd; iCfgOK = 1'b1; iStart = 1'b1;
        @(posedge clk); #2;
        build(cfg, int'(qtd));
        busy_cnt = 0; wr_cnt = 0; done_cnt = 0;
        addr_log.delete(); bias_log.delete(); wrl_log.delete();
        @(negedge clk); #1;
        iStart = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk); #3;
            n++;
        end
        chk({nm, "_timeout"}, q.size(), 0);
        q.delete();
    endtask

    task automatic chk_addrs(input string nm, input int n);
        chk({nm, "_naddr"}, addr_log.size(), n);
        for (int i = 0; i < addr_log.size() && i < n; i++) chk({nm, "_addr"}, addr_log[i], i);
    endtask

    logic [13*MAX_CAM-1:0] cfg1, cfg2, cfg4;

    initial begin
        cfg1 = {39'd0, lc(3, 0, 1, 2)};
        cfg2 = {26'd0, lc(1, 0, 0, 2), lc(2, 1, 2, 3)};
        cfg4 = {lc(2, 0, 1, 0), lc(1, 1, 2, 0), lc(0, 1, 3, 4), lc(1, 0, 0, 1)};

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("reset_outs", {oBusy, oDone, oMacClr, oMacEn, oBiasEn, oActEn, oWrEn,
                              oLayer, oNeuron, oAddrX, oAddrW, oFA}, 0);
        rst = 1'b1;

        // start without valid config is ignored
        @(negedge clk); #1;
        iCfg = cfg1; iQtdCamadas = 3'd1; iCfgOK = 1'b0; iStart = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("nocfg_busy", oBusy, 0);
        iStart = 1'b0;

        // single layer; config changes and a start pulse mid-pass must not disturb it
        start_pass(cfg1, 3'd1);
        @(negedge clk); #1;
        iCfg = {39'd0, lc(7, 1, 3, 9)}; iStart = 1'b1;
        @(negedge clk); #1;
        iStart = 1'b0;
        wait_done("t1");
        chk("t1_busy", busy_cnt, 17);
        chk("t1_wr", wr_cnt, 3);
        chk("t1_done", done_cnt, 1);
        chk("t1_nbias", bias_log.size(), 0);
        chk_addrs("t1", 6);

        // two layers with bias on layer 0
        start_pass(cfg2, 3'd2);
        wait_done("t2");
        chk("t2_busy", busy_cnt, 22);
        chk("t2_wr", wr_cnt, 3);
        chk_addrs("t2", 10);
        chk("t2_nbias", bias_log.size(), 2);
        if (bias_log.size() == 2) begin
            chk("t2_bias0", bias_log[0], 3);
            chk("t2_bias1", bias_log[1], 7);
        end
        if (wrl_log.size() == 3) chk("t2_wrlayers", {wrl_log[0], wrl_log[1], wrl_log[2]}, {32'd0, 32'd0, 32'd1});

        // three-cycle MAC stall on input 1
        start_pass(cfg1, 3'd1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        iMacRdy = 1'b0;
        @(negedge clk); #1;
        chk("stall_hold", {oMacEn, oAddrX, oAddrW}, {1'b1, 5'd1, 10'd1});
        @(negedge clk); #1;
        chk("stall_hold2", {oMacEn, oAddrX, oAddrW}, {1'b1, 5'd1, 10'd1});
        @(negedge clk); #1;
        iMacRdy = 1'b1;
        wait_done("stall");
        chk("stall_busy", busy_cnt, 20);
        chk_addrs("stall", 6);

        // zero layers
        start_pass(cfg1, 3'd0);
        wait_done("q0");
        chk("q0_busy", busy_cnt, 2);
        chk("q0_wr", wr_cnt, 0);
        chk("q0_naddr", addr_log.size(), 0);

        // count clamps to four layers, layer 1 empty
        start_pass(cfg4, 3'd7);
        wait_done("q7");
        chk("q7_busy", busy_cnt, 19);
        chk("q7_wr", wr_cnt, 4);
        chk_addrs("q7", 2);
        if (wrl_log.size() == 4) chk("q7_wrlayers", {wrl_log[0], wrl_log[1], wrl_log[2], wrl_log[3]},
                                     {32'd0, 32'd2, 32'd3, 32'd3});

        // asynchronous reset in the middle of MAC
        start_pass(cfg1, 3'd1);
        @(negedge clk);
        @(negedge clk); #3;
        chk("pre_rst_mac", oMacEn, 1);
        rst = 1'b0;
        q.delete();
        #1 chk("midrst_outs", {oBusy, oDone, oMacClr, oMacEn, oBiasEn, oActEn, oWrEn,
                               oLayer, oNeuron, oAddrX, oAddrW, oFA}, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        start_pass(cfg2, 3'd2);
        wait_done("post_rst");
        chk("post_rst_busy", busy_cnt, 22);
        chk_addrs("post_rst", 10);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
